// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pooling datapath: FSM state encoding,
// default sample width and a helper for sizing index/address fields.
package cnn_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_state_t;

  // Width of an index that counts 0..depth-1, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/maxpool_stage_if.sv
// Streaming handshake bundle between the convolution write path, the
// pooling stage and the pooled-sample consumer. The stage uses the slave
// modport; whoever feeds samples and drains results uses master.
interface maxpool_stage_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/pool_line_buffer.sv
// One-row buffer of horizontal pair maxima for the 2x2 pooling window.
// One synchronous write port, one asynchronous read port; contents are
// not reset because every entry is written on an even row before it is
// read on the following odd row.
module pool_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  // Store the even-row pair maximum for the window column being built.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_stage.sv
// 2x2 stride-2 max-pooling stage fed row-major by the convolution
// controller. Horizontal pairs are reduced as samples arrive; even rows
// park their pair maxima in a line buffer, odd rows combine with it and
// emit one pooled sample per window through a one-deep output register.
// Optional build macro: MAXPOOL_RELU_EN clamps negative pooled results
// to zero; without it the raw signed maximum is emitted.
module maxpool_stage
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int MAP_W  = 8,
  parameter int MAP_H  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  maxpool_stage_if.slave bus,
  output logic           busy,
  output logic           done
);

  localparam int COL_W    = addr_width(MAP_W);
  localparam int ROW_W    = addr_width(MAP_H);
  localparam int LB_DEPTH = MAP_W / 2;
  localparam int LB_AW    = addr_width(LB_DEPTH);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_H - 1);

  pool_state_t state;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic signed [DATA_W-1:0] pair_reg;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] pool_max;
  logic signed [DATA_W-1:0] pool_out;

  logic             xfer;
  logic             last_in;
  logic             lb_we;
  logic             out_load;
  logic [LB_AW-1:0] lb_addr;

  // Accept only while running and the output register can take a result.
  assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign last_in      = (col == COL_LAST) && (row == ROW_LAST);

  // Odd columns close a horizontal pair; row parity picks park vs. emit.
  assign lb_addr  = LB_AW'(col >> 1);
  assign lb_we    = xfer && col[0] && !row[0];
  assign out_load = xfer && col[0] && row[0];

  // Signed max with strict greater-than so a tie keeps the earlier sample.
  assign pair_max = (bus.in_data > pair_reg) ? bus.in_data : pair_reg;
  assign pool_max = (pair_max > lb_rd) ? pair_max : lb_rd;

`ifdef MAXPOOL_RELU_EN
  assign pool_out = pool_max[DATA_W-1] ? '0 : pool_max;
`else
  assign pool_out = pool_max;
`endif

  pool_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_DEPTH),
    .AW     (LB_AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rd)
  );

  // Pass sequencing with busy/done registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (xfer && last_in) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus.out_valid || bus.out_ready) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Track the position of the next incoming sample within the map.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if ((state == IDLE) && start) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Hold the left sample of each horizontal pair until its partner arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_reg <= '0;
    end else if (xfer && !col[0]) begin
      pair_reg <= bus.in_data;
    end
  end

  // One-deep output register; a new result may overwrite one being taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (out_load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= pool_out;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_stage.sv
// Directed bench for maxpool_stage: a 4x4 instance for the hand-computed
// scenarios and an 8x8 instance for randomised handshake gaps.
// Honours MAXPOOL_RELU_EN when computing expected pooled values.
module tb_maxpool_stage;

  logic clk;
  logic rst;
  logic start4, start8;
  logic busy4, done4, busy8, done8;

  int tests_run;
  int tests_failed;

  logic signed [7:0] vec4 [16];
  logic signed [7:0] exp4 [4];
  logic signed [7:0] got4 [$];
  logic signed [7:0] stall_data [$];
  logic              stall_ready [$];
  logic signed [7:0] vec8 [64];
  bit                saw_done4;
  int                in_count4;

  maxpool_stage_if #(.DATA_W(8)) if4 ();
  maxpool_stage_if #(.DATA_W(8)) if8 ();

  maxpool_stage #(.DATA_W(8), .MAP_W(4), .MAP_H(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .bus   (if4),
    .busy  (busy4),
    .done  (done4)
  );

  maxpool_stage #(.DATA_W(8), .MAP_W(8), .MAP_H(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .bus   (if8),
    .busy  (busy8),
    .done  (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run one 4x4 pass from vec4; optionally stall out_ready after the first
  // result and pulse start at a given loop cycle while the pass is running.
  task automatic stream4(input int stall_cycles, input int pulse_cyc);
    int idx;
    int cyc;
    int stall_left;
    bit stalled_once;
    idx = 0; cyc = 0; stall_left = 0; stalled_once = 1'b0;
    saw_done4 = 1'b0;
    got4.delete(); stall_data.delete(); stall_ready.delete();
    @(negedge clk);
    start4 = 1'b1;
    while (!saw_done4 && cyc < 200) begin
      @(negedge clk);
      start4 = (cyc == pulse_cyc);
      if (stall_cycles > 0 && !stalled_once && if4.out_valid) begin
        stall_left   = stall_cycles;
        stalled_once = 1'b1;
      end
      if4.out_ready = (stall_left == 0);
      if4.in_valid  = (idx < 16);
      if4.in_data   = (idx < 16) ? vec4[idx] : 8'sd0;
      #1;
      if (stall_left > 0) begin
        stall_data.push_back(if4.out_data);
        stall_ready.push_back(if4.in_ready);
        stall_left--;
      end
      if (if4.in_valid && if4.in_ready) idx++;
      if (if4.out_valid && if4.out_ready) got4.push_back(if4.out_data);
      if (done4) saw_done4 = 1'b1;
      cyc++;
    end
    start4        = 1'b0;
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    in_count4     = idx;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    tests_run++;
    if (if4.out_valid !== 1'b0 || if4.out_data !== 8'sd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out: got valid=%b data=%0d expected valid=0 data=0", if4.out_valid, if4.out_data);
    end
    tests_run++;
    if (if4.in_ready !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got in_ready=%b busy=%b done=%b expected 0 0 0", if4.in_ready, busy4, done4);
    end
    tests_run++;
    if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b0 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_dut8: got valid=%b in_ready=%b busy=%b expected 0 0 0", if8.out_valid, if8.in_ready, busy8);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) vec4[i] = 8'(i);
    exp4[0] = 8'sd5; exp4[1] = 8'sd7; exp4[2] = 8'sd13; exp4[3] = 8'sd15;
    stream4(0, -1);
    tests_run++;
    if (!saw_done4 || got4.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL basic_count: got %0d outputs done=%0b expected 4 outputs done=1", got4.size(), saw_done4);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= got4.size()) begin
        tests_failed++;
        $display("[TB] FAIL basic_out%0d: got none expected %0d", k, exp4[k]);
      end else if (got4[k] !== exp4[k]) begin
        tests_failed++;
        $display("[TB] FAIL basic_out%0d: got %0d expected %0d", k, got4[k], exp4[k]);
      end
    end
    tests_run++;
    if (busy4 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy4);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (done4 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_done_pulse: got %b one cycle later expected 0", done4);
    end
  endtask

  task automatic test_relu();
    vec4 = '{-8'sd3, -8'sd8, 8'sd10, -8'sd2,
             -8'sd1, -8'sd5, 8'sd3, 8'sd9,
             8'sh80, -8'sd127, 8'sd4, 8'sd4,
             8'sh80, -8'sd100, 8'sd4, 8'sd4};
`ifdef MAXPOOL_RELU_EN
    exp4[0] = 8'sd0; exp4[1] = 8'sd10; exp4[2] = 8'sd0; exp4[3] = 8'sd4;
`else
    exp4[0] = -8'sd1; exp4[1] = 8'sd10; exp4[2] = -8'sd100; exp4[3] = 8'sd4;
`endif
    stream4(0, -1);
    tests_run++;
    if (!saw_done4 || got4.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL relu_count: got %0d outputs done=%0b expected 4 outputs done=1", got4.size(), saw_done4);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= got4.size()) begin
        tests_failed++;
        $display("[TB] FAIL relu_out%0d: got none expected %0d", k, exp4[k]);
      end else if (got4[k] !== exp4[k]) begin
        tests_failed++;
        $display("[TB] FAIL relu_out%0d: got %0d expected %0d", k, got4[k], exp4[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) vec4[i] = 8'(i);
    exp4[0] = 8'sd5; exp4[1] = 8'sd7; exp4[2] = 8'sd13; exp4[3] = 8'sd15;
    stream4(8, -1);
    tests_run++;
    if (stall_data.size() != 8) begin
      tests_failed++;
      $display("[TB] FAIL bp_stall_len: got %0d stalled cycles expected 8", stall_data.size());
    end
    for (int k = 0; k < stall_data.size(); k++) begin
      tests_run++;
      if (stall_ready[k] !== 1'b0 || stall_data[k] !== 8'sd5) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold%0d: got in_ready=%b data=%0d expected in_ready=0 data=5", k, stall_ready[k], stall_data[k]);
      end
    end
    tests_run++;
    if (in_count4 != 16 || got4.size() != 4 || !saw_done4) begin
      tests_failed++;
      $display("[TB] FAIL bp_count: got inputs=%0d outputs=%0d done=%0b expected 16 4 1", in_count4, got4.size(), saw_done4);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= got4.size()) begin
        tests_failed++;
        $display("[TB] FAIL bp_out%0d: got none expected %0d", k, exp4[k]);
      end else if (got4[k] !== exp4[k]) begin
        tests_failed++;
        $display("[TB] FAIL bp_out%0d: got %0d expected %0d", k, got4[k], exp4[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int idx;
    int cyc;
    int bad;
    for (int i = 0; i < 16; i++) vec4[i] = 8'(i);
    idx = 0; cyc = 0; bad = 0;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    while (idx < 6 && cyc < 50) begin
      if4.out_ready = 1'b1;
      if4.in_valid  = 1'b1;
      if4.in_data   = vec4[idx];
      #1;
      if (if4.in_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    if4.in_valid = 1'b0;
    tests_run++;
    if (if4.out_valid !== 1'b1 || if4.out_data !== 8'sd5) begin
      tests_failed++;
      $display("[TB] FAIL midrst_latency: got valid=%b data=%0d expected valid=1 data=5", if4.out_valid, if4.out_data);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (if4.out_valid !== 1'b0 || if4.out_data !== 8'sd0 || if4.in_ready !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_clear: got valid=%b data=%0d in_ready=%b busy=%b done=%b expected 0 0 0 0 0",
               if4.out_valid, if4.out_data, if4.in_ready, busy4, done4);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if4.in_valid = 1'b1;
      if4.in_data  = 8'sd77;
      #1;
      if (if4.out_valid || busy4 || if4.in_ready) bad++;
    end
    if4.in_valid = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_quiet: got %0d active cycles before start expected 0", bad);
    end
    exp4[0] = 8'sd5; exp4[1] = 8'sd7; exp4[2] = 8'sd13; exp4[3] = 8'sd15;
    stream4(0, -1);
    tests_run++;
    if (!saw_done4 || got4.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL midrst_count: got %0d outputs done=%0b expected 4 outputs done=1", got4.size(), saw_done4);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= got4.size()) begin
        tests_failed++;
        $display("[TB] FAIL midrst_out%0d: got none expected %0d", k, exp4[k]);
      end else if (got4[k] !== exp4[k]) begin
        tests_failed++;
        $display("[TB] FAIL midrst_out%0d: got %0d expected %0d", k, got4[k], exp4[k]);
      end
    end
  endtask

  task automatic test_spurious();
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if4.in_valid = 1'b1;
      if4.in_data  = 8'sd99;
      #1;
      tests_run++;
      if (if4.in_ready !== 1'b0 || if4.out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL idle_ignore%0d: got in_ready=%b out_valid=%b expected 0 0", i, if4.in_ready, if4.out_valid);
      end
    end
    if4.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) vec4[i] = 8'(i);
    exp4[0] = 8'sd5; exp4[1] = 8'sd7; exp4[2] = 8'sd13; exp4[3] = 8'sd15;
    stream4(0, 3);
    tests_run++;
    if (!saw_done4 || got4.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL runstart_count: got %0d outputs done=%0b expected 4 outputs done=1", got4.size(), saw_done4);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= got4.size()) begin
        tests_failed++;
        $display("[TB] FAIL runstart_out%0d: got none expected %0d", k, exp4[k]);
      end else if (got4[k] !== exp4[k]) begin
        tests_failed++;
        $display("[TB] FAIL runstart_out%0d: got %0d expected %0d", k, got4[k], exp4[k]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (if4.out_valid || busy4) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL runstart_extra: got %0d active cycles after done expected 0", bad);
    end
  endtask

  task automatic test_random8();
    int idx;
    int cyc;
    bit seen;
    logic signed [7:0] m;
    logic signed [7:0] exp8 [16];
    logic signed [7:0] got8 [$];
    for (int i = 0; i < 64; i++) vec8[i] = 8'($urandom_range(0, 255));
    vec8[0]  = 8'sh80;
    vec8[9]  = 8'sh7F;
    vec8[20] = 8'sh80; vec8[21] = 8'sh80; vec8[28] = 8'sh80; vec8[29] = 8'sh80;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        m = vec8[(2*r)*8 + 2*c];
        if (vec8[(2*r)*8 + 2*c + 1] > m) m = vec8[(2*r)*8 + 2*c + 1];
        if (vec8[(2*r+1)*8 + 2*c] > m) m = vec8[(2*r+1)*8 + 2*c];
        if (vec8[(2*r+1)*8 + 2*c + 1] > m) m = vec8[(2*r+1)*8 + 2*c + 1];
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 8'sd0;
`endif
        exp8[r*4 + c] = m;
      end
    end
    idx = 0; cyc = 0; seen = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      start8 = 1'b0;
      if8.in_valid  = (idx < 64) && ($urandom_range(0, 9) < 7);
      if8.in_data   = (idx < 64) ? vec8[idx] : 8'sd0;
      if8.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (if8.in_valid && if8.in_ready) idx++;
      if (if8.out_valid && if8.out_ready) got8.push_back(if8.out_data);
      if (done8) seen = 1'b1;
      cyc++;
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    tests_run++;
    if (!seen || got8.size() != 16 || idx != 64) begin
      tests_failed++;
      $display("[TB] FAIL rand8_count: got outputs=%0d inputs=%0d done=%0b expected 16 64 1", got8.size(), idx, seen);
    end
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (k >= got8.size()) begin
        tests_failed++;
        $display("[TB] FAIL rand8_out%0d: got none expected %0d", k, exp8[k]);
      end else if (got8[k] !== exp8[k]) begin
        tests_failed++;
        $display("[TB] FAIL rand8_out%0d: got %0d expected %0d", k, got8[k], exp8[k]);
      end
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b0;
    start4        = 1'b0;
    start8        = 1'b0;
    if4.in_valid  = 1'b0;
    if4.in_data   = 8'sd0;
    if4.out_ready = 1'b1;
    if8.in_valid  = 1'b0;
    if8.in_data   = 8'sd0;
    if8.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_relu();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    test_random8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/maxpool_stage.md
MAXPOOL_STAGE -- requirements
Module: maxpool_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed sample width of the convolution output.
REQ-002 SHALL have parameter MAP_W, default 8, feature-map columns; even, >=2.
REQ-003 SHALL have parameter MAP_H, default 8, feature-map rows; even, >=2.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin one pooling pass; sampled only in IDLE.
REQ-007 SHALL have port in_valid  input  1  in_data valid (from convolution controller write path).
REQ-008 SHALL have port in_ready  output  1  stage accepts in_data this cycle.
REQ-009 SHALL have port in_data  input  DATA_W  conv sample, signed, row-major.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-012 SHALL have port out_data  output  DATA_W  pooled sample, signed.
REQ-013 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-014 SHALL have port done  output  1  one-cycle pulse at pass end.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN after last input (row MAP_H-1, col MAP_W-1) accepted; DRAIN -> DONE when output register empty or emptied by out_ready; DONE -> IDLE unconditionally.
REQ-016 SHALL assert done only in DONE; busy only in RUN/DRAIN.
REQ-017 SHALL transfer input when in_valid && in_ready; in_ready = RUN && (!out_valid || out_ready).
REQ-018 SHALL keep col (0..MAP_W-1) and row (0..MAP_H-1) counters, advancing col on each transfer, wrapping col to 0 and incrementing row at MAP_W-1; both clear on start.
REQ-019 SHALL hold pair register: even col loads sample; odd col forms pair_max = signed max(pair_reg, in_data).
REQ-020 SHALL, on even row odd col, write pair_max to line buffer entry col/2 (MAP_W/2 entries, DATA_W each).
REQ-021 SHALL, on odd row odd col, load out_data = signed max(pair_max, linebuf[col/2]) and set out_valid next cycle (latency 1 from final window transfer).
REQ-022 SHALL clear out_valid on out_ready with no new load; simultaneous load and out_ready SHALL replace data, out_valid stays 1.
REQ-023 SHALL compare with ties yielding the earlier sample; no saturation or width growth.
REQ-024 SHALL ignore start outside IDLE; ignore in_valid in IDLE, DRAIN, DONE.
REQ-025 SHALL produce exactly (MAP_W/2)*(MAP_H/2) outputs per pass, in row-major pooled order.

Reset
REQ-026 SHALL on rst low asynchronously force IDLE, counters 0, pair_reg 0, out_valid 0, out_data 0, done 0, busy 0, in_ready 0; line buffer contents need no reset.
REQ-027 SHALL abandon a pass on reset mid-operation; no output produced until a new start.

Configuration
REQ-028 SHALL, with MAXPOOL_RELU_EN defined, clamp negative results of REQ-021 to 0 before out_data; without it, out_data SHALL be the raw signed max.

Structure
REQ-029 SHALL place FSM state enum (IDLE, RUN, DRAIN, DONE) and default DATA_W in shared package cnn_pkg.
REQ-030 SHALL instantiate one sub-module pool_line_buffer (MAP_W/2 x DATA_W, one write, one async read port).
REQ-031 SHALL keep the signed max comparator as local combinational logic, not a module.

Verification
REQ-032 SHALL cover MAP_W=MAP_H=4, inputs 0..15 row-major, out_ready=1 -> outputs 5,7,13,15 then done pulse.
REQ-033 SHALL cover window {-3,-8,-1,-5} -> out_data -1 without macro, 0 with MAXPOOL_RELU_EN.
REQ-034 SHALL cover out_ready held 0 after first output -> in_ready 0, out_data held 5, no input lost when released.
REQ-035 SHALL cover rst low after 6 inputs -> all outputs 0 immediately; new start then 16 inputs -> 4 correct outputs.
REQ-036 SHALL cover start pulsed during RUN and in_valid in IDLE -> no counter change, no extra output.
REQ-037 SHALL cover random in_valid/out_ready gaps, 8x8 map -> 16 outputs matching reference max model.
